// File: rtl/axis_checksum_appender.sv
// AXI-Stream pass-through that appends a modulo-2^DATA_WIDTH checksum beat
// (sum of byte-masked data beats) after the last beat of every frame.
module axis_checksum_appender #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                    s03_axis_aclk,
   input  logic                    s03_axis_aresetn,
   input  logic [DATA_WIDTH-1:0]   s03_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s03_axis_tstrb,
   input  logic                    s03_axis_tvalid,
   input  logic                    s03_axis_tlast,
   output logic                    s03_axis_tready,
   input  logic                    m03_axis_tready,
   output logic [DATA_WIDTH-1:0]   m03_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m03_axis_tstrb,
   output logic                    m03_axis_tvalid,
   output logic                    m03_axis_tlast,
   output logic [CNT_WIDTH-1:0]    frame_count
);

   localparam int STRB_W = DATA_WIDTH / 8;

   typedef enum logic {PASS = 1'b0, CSUM = 1'b1} state_t;

   state_t                  state, state_nxt;
   logic [DATA_WIDTH-1:0]   acc, acc_nxt;
   logic                    slot_free;
   logic                    in_fire;
   logic                    csum_load;

   // Bytes whose strobe is low contribute zero to the checksum.
   function automatic logic [DATA_WIDTH-1:0] mask_beat(
      input logic [DATA_WIDTH-1:0] d,
      input logic [STRB_W-1:0]     s
   );
      logic [DATA_WIDTH-1:0] m;
      m = '0;
      for (int i = 0; i < STRB_W; i++) begin
         if (s[i]) m[i*8 +: 8] = d[i*8 +: 8];
      end
      return m;
   endfunction

   assign slot_free       = !m03_axis_tvalid || m03_axis_tready;
   assign s03_axis_tready = s03_axis_aresetn && (state == PASS) && slot_free;
   assign in_fire         = s03_axis_tvalid && s03_axis_tready;
   assign csum_load       = (state == CSUM) && slot_free;

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      case (state)
         PASS: begin
            if (in_fire) begin
               acc_nxt = acc + mask_beat(s03_axis_tdata, s03_axis_tstrb);
               if (s03_axis_tlast) state_nxt = CSUM;
            end
         end
         CSUM: begin
            if (slot_free) begin
               acc_nxt   = '0;
               state_nxt = PASS;
            end
         end
         default: state_nxt = PASS;
      endcase
   end

   always_ff @(posedge s03_axis_aclk or negedge s03_axis_aresetn) begin
      if (!s03_axis_aresetn) begin
         state <= PASS;
         acc   <= '0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
      end
   end

   // Output register stage: data beat, checksum beat, or drain.
   always_ff @(posedge s03_axis_aclk or negedge s03_axis_aresetn) begin
      if (!s03_axis_aresetn) begin
         m03_axis_tvalid <= 1'b0;
         m03_axis_tlast  <= 1'b0;
         m03_axis_tdata  <= '0;
         m03_axis_tstrb  <= '0;
      end else if (slot_free) begin
         if (in_fire) begin
            m03_axis_tvalid <= 1'b1;
            m03_axis_tlast  <= 1'b0;
            m03_axis_tdata  <= s03_axis_tdata;
            m03_axis_tstrb  <= s03_axis_tstrb;
         end else if (csum_load) begin
            m03_axis_tvalid <= 1'b1;
            m03_axis_tlast  <= 1'b1;
            m03_axis_tdata  <= acc;
            m03_axis_tstrb  <= '1;
         end else begin
            m03_axis_tvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge s03_axis_aclk or negedge s03_axis_aresetn) begin
      if (!s03_axis_aresetn) begin
         frame_count <= '0;
      end else if (m03_axis_tvalid && m03_axis_tready && m03_axis_tlast) begin
         frame_count <= frame_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_axis_checksum_appender.sv
// Directed bench for axis_checksum_appender: pass-through, masked checksum,
// wrap-around, output stalls, back-to-back frames and mid-frame reset.
module tb_axis_checksum_appender;

   logic        clk;
   logic        rst_n;
   logic [31:0] s_tdata;
   logic [3:0]  s_tstrb;
   logic        s_tvalid;
   logic        s_tlast;
   logic        s_tready;
   logic        m_tready;
   logic [31:0] m_tdata;
   logic [3:0]  m_tstrb;
   logic        m_tvalid;
   logic        m_tlast;
   logic [15:0] frame_count;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   logic        toggle_en = 1'b0;

   logic [31:0] q_data[$];
   logic [3:0]  q_strb[$];
   logic        q_last[$];
   int          q_cyc[$];

   axis_checksum_appender #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
      .s03_axis_aclk    (clk),
      .s03_axis_aresetn (rst_n),
      .s03_axis_tdata   (s_tdata),
      .s03_axis_tstrb   (s_tstrb),
      .s03_axis_tvalid  (s_tvalid),
      .s03_axis_tlast   (s_tlast),
      .s03_axis_tready  (s_tready),
      .m03_axis_tready  (m_tready),
      .m03_axis_tdata   (m_tdata),
      .m03_axis_tstrb   (m_tstrb),
      .m03_axis_tvalid  (m_tvalid),
      .m03_axis_tlast   (m_tlast),
      .frame_count      (frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Downstream ready: constant 1, or toggling every cycle when enabled.
   initial m_tready = 1'b1;
   always @(posedge clk) begin
      #1;
      m_tready = toggle_en ? ~m_tready : 1'b1;
   end

   // Output monitor at the falling edge: capture transfers, check stall stability.
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data;
   logic [3:0]  prev_strb;
   logic        prev_last;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", m_tvalid, 1'b1);
            check("stall_data", m_tdata, prev_data);
            check("stall_strb", m_tstrb, prev_strb);
            check("stall_last", m_tlast, prev_last);
         end
         if (m_tvalid && !m_tready) begin
            check("stall_s_tready", s_tready, 1'b0);
            prev_stall = 1'b1;
            prev_data  = m_tdata;
            prev_strb  = m_tstrb;
            prev_last  = m_tlast;
         end else begin
            prev_stall = 1'b0;
         end
         if (m_tvalid && m_tready) begin
            q_data.push_back(m_tdata);
            q_strb.push_back(m_tstrb);
            q_last.push_back(m_tlast);
            q_cyc.push_back(cyc);
         end
      end
   end

   task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
      logic rdy;
      int   waited;
      s_tdata  = d;
      s_tstrb  = s;
      s_tlast  = l;
      s_tvalid = 1'b1;
      waited   = 0;
      rdy      = 1'b0;
      while (!rdy && waited < 50) begin
         @(negedge clk);
         rdy = s_tready;
         @(posedge clk);
         waited++;
      end
      check("send_timeout", rdy, 1'b1);
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic wait_out(input int n);
      int waited;
      waited = 0;
      while (q_data.size() < n && waited < 60) begin
         @(posedge clk);
         waited++;
      end
      repeat (4) @(posedge clk);
      #1;
      check("out_count", q_data.size(), n);
   endtask

   task automatic chk_beat(input string tag, input int idx, input logic [31:0] d,
                           input logic [3:0] s, input logic l);
      if (idx < q_data.size()) begin
         check({tag, "_data"}, q_data[idx], d);
         check({tag, "_strb"}, q_strb[idx], s);
         check({tag, "_last"}, q_last[idx], l);
      end else begin
         check({tag, "_missing"}, q_data.size(), idx + 1);
      end
   endtask

   task automatic clear_q();
      q_data.delete();
      q_strb.delete();
      q_last.delete();
      q_cyc.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      s_tdata  = '0;
      s_tstrb  = '0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_m_tvalid", m_tvalid, 1'b0);
      check("rst_m_tlast", m_tlast, 1'b0);
      check("rst_m_tdata", m_tdata, 32'h0);
      check("rst_m_tstrb", m_tstrb, 4'h0);
      check("rst_frame_count", frame_count, 16'h0);
      check("rst_s_tready", s_tready, 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Three-beat frame with full strobes.
      send_beat(32'h1, 4'hF, 1'b0);
      send_beat(32'h2, 4'hF, 1'b0);
      send_beat(32'h3, 4'hF, 1'b1);
      wait_out(4);
      chk_beat("t1_b0", 0, 32'h1, 4'hF, 1'b0);
      chk_beat("t1_b1", 1, 32'h2, 4'hF, 1'b0);
      chk_beat("t1_b2", 2, 32'h3, 4'hF, 1'b0);
      chk_beat("t1_cs", 3, 32'h6, 4'hF, 1'b1);
      check("t1_frame_count", frame_count, 16'd1);
      clear_q();

      // One-beat frame with partial strobes.
      send_beat(32'hAABBCCDD, 4'h3, 1'b1);
      wait_out(2);
      chk_beat("t2_b0", 0, 32'hAABBCCDD, 4'h3, 1'b0);
      chk_beat("t2_cs", 1, 32'h0000CCDD, 4'hF, 1'b1);
      check("t2_frame_count", frame_count, 16'd2);
      clear_q();

      // Sum wraps modulo 2^32.
      send_beat(32'hFFFFFFFF, 4'hF, 1'b0);
      send_beat(32'h00000002, 4'hF, 1'b1);
      wait_out(3);
      chk_beat("t3_b0", 0, 32'hFFFFFFFF, 4'hF, 1'b0);
      chk_beat("t3_b1", 1, 32'h00000002, 4'hF, 1'b0);
      chk_beat("t3_cs", 2, 32'h00000001, 4'hF, 1'b1);
      check("t3_frame_count", frame_count, 16'd3);
      clear_q();

      // Downstream ready toggling each cycle.
      toggle_en = 1'b1;
      send_beat(32'h10, 4'hF, 1'b0);
      send_beat(32'h20, 4'hF, 1'b1);
      wait_out(3);
      toggle_en = 1'b0;
      chk_beat("t4_b0", 0, 32'h10, 4'hF, 1'b0);
      chk_beat("t4_b1", 1, 32'h20, 4'hF, 1'b0);
      chk_beat("t4_cs", 2, 32'h30, 4'hF, 1'b1);
      check("t4_frame_count", frame_count, 16'd4);
      repeat (2) @(posedge clk);
      #1;
      clear_q();

      // Back-to-back one-beat frames: transfers on consecutive cycles.
      send_beat(32'h5, 4'hF, 1'b1);
      send_beat(32'h7, 4'hF, 1'b1);
      wait_out(4);
      chk_beat("t5_b0", 0, 32'h5, 4'hF, 1'b0);
      chk_beat("t5_cs0", 1, 32'h5, 4'hF, 1'b1);
      chk_beat("t5_b1", 2, 32'h7, 4'hF, 1'b0);
      chk_beat("t5_cs1", 3, 32'h7, 4'hF, 1'b1);
      if (q_cyc.size() == 4) check("t5_span", q_cyc[3] - q_cyc[0], 3);
      check("t5_frame_count", frame_count, 16'd6);
      clear_q();

      // Reset mid-frame discards partial frame and sum.
      send_beat(32'h8, 4'hF, 1'b0);
      send_beat(32'h9, 4'hF, 1'b0);
      rst_n = 1'b0;
      #1;
      check("t6_rst_m_tvalid", m_tvalid, 1'b0);
      check("t6_rst_s_tready", s_tready, 1'b0);
      check("t6_rst_frame_count", frame_count, 16'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_q();
      @(posedge clk);
      #1;
      send_beat(32'h4, 4'hF, 1'b1);
      wait_out(2);
      chk_beat("t6_b0", 0, 32'h4, 4'hF, 1'b0);
      chk_beat("t6_cs", 1, 32'h4, 4'hF, 1'b1);
      check("t6_frame_count", frame_count, 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
